// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU operation codes and forward-select encoding.
package pipe_pkg;

  localparam logic [4:0] ALU_AND = 5'd0;
  localparam logic [4:0] ALU_OR  = 5'd1;
  localparam logic [4:0] ALU_ADD = 5'd2;
  localparam logic [4:0] ALU_SUB = 5'd3;
  localparam logic [4:0] ALU_SLT = 5'd4;
  localparam logic [4:0] ALU_NOR = 5'd5;
  localparam logic [4:0] ALU_XOR = 5'd6;
  localparam logic [4:0] ALU_SLL = 5'd7;
  localparam logic [4:0] ALU_SRL = 5'd8;
  localparam logic [4:0] ALU_SRA = 5'd9;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Forwarding mux for one source register. EX/MEM beats MEM/WB; r0 is never forwarded.
module fwd_mux
  import pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] reg_val,
  input  logic          exmem_en,
  input  logic [AW-1:0] exmem_dst,
  input  logic [DW-1:0] exmem_val,
  input  logic          memwb_en,
  input  logic [AW-1:0] memwb_dst,
  input  logic [DW-1:0] memwb_val,
  output logic [DW-1:0] val,
  output fwd_sel_e      sel
);

  // Pick the youngest producer of addr, falling back to the registered value.
  always_comb begin
    sel = FWD_REG;
    val = reg_val;
    if (addr != '0) begin
      if (exmem_en && exmem_dst == addr) begin
        sel = FWD_EXMEM;
        val = exmem_val;
      end else if (memwb_en && memwb_dst == addr) begin
        sel = FWD_MEMWB;
        val = memwb_val;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble insertion,
// flush and downstream hold.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs_addr,
  input  logic [AW-1:0] id_rt_addr,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_shamt,
  input  logic [4:0]    id_alu_conf,
  input  logic          id_sign,
  input  logic          id_alu_src1,
  input  logic          id_alu_src2,
  input  logic [AW-1:0] id_dst_addr,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          flush,
  input  logic          ex_hold,
  input  logic          exmem_reg_write,
  input  logic [AW-1:0] exmem_dst,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [AW-1:0] memwb_dst,
  input  logic [DW-1:0] memwb_data,
  output logic          stall_id,
  output logic          ex_valid,
  output logic [4:0]    ex_alu_conf,
  output logic          ex_sign,
  output logic [DW-1:0] ex_in1,
  output logic [DW-1:0] ex_in2,
  output logic [DW-1:0] ex_store_data,
  output logic [AW-1:0] ex_dst,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write
);

  logic [AW-1:0] ex_rs_addr, ex_rt_addr;
  logic [DW-1:0] ex_rs_val, ex_rt_val, ex_imm;
  logic [4:0]    ex_shamt;
  logic          ex_alu_src1, ex_alu_src2;

  logic [DW-1:0] rs_fwd, rt_fwd, rs_byp, rt_byp;
  fwd_sel_e      rs_sel, rt_sel, rs_byp_sel, rt_byp_sel;
  logic          lu;

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rs (
    .addr(ex_rs_addr), .reg_val(ex_rs_val),
    .exmem_en(exmem_reg_write), .exmem_dst(exmem_dst), .exmem_val(exmem_result),
    .memwb_en(memwb_reg_write), .memwb_dst(memwb_dst), .memwb_val(memwb_data),
    .val(rs_fwd), .sel(rs_sel)
  );

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rt (
    .addr(ex_rt_addr), .reg_val(ex_rt_val),
    .exmem_en(exmem_reg_write), .exmem_dst(exmem_dst), .exmem_val(exmem_result),
    .memwb_en(memwb_reg_write), .memwb_dst(memwb_dst), .memwb_val(memwb_data),
    .val(rt_fwd), .sel(rt_sel)
  );

  // Capture-time bypass: only the writeback stage can be ahead of a fresh ID read.
  fwd_mux #(.DW(DW), .AW(AW)) u_byp_rs (
    .addr(id_rs_addr), .reg_val(id_rs_data),
    .exmem_en(1'b0), .exmem_dst('0), .exmem_val('0),
    .memwb_en(memwb_reg_write), .memwb_dst(memwb_dst), .memwb_val(memwb_data),
    .val(rs_byp), .sel(rs_byp_sel)
  );

  fwd_mux #(.DW(DW), .AW(AW)) u_byp_rt (
    .addr(id_rt_addr), .reg_val(id_rt_data),
    .exmem_en(1'b0), .exmem_dst('0), .exmem_val('0),
    .memwb_en(memwb_reg_write), .memwb_dst(memwb_dst), .memwb_val(memwb_data),
    .val(rt_byp), .sel(rt_byp_sel)
  );

  // Load in EX whose result a live ID instruction needs: one bubble is required.
  always_comb begin
    lu = ex_valid && ex_mem_read && (ex_dst != '0) && id_valid &&
         ((id_uses_rs && id_rs_addr == ex_dst) || (id_uses_rt && id_rt_addr == ex_dst));
    stall_id = lu || ex_hold;
  end

  // EX register: hold re-latches forwarded operands, flush/lu load a bubble, else capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_rs_addr   <= '0;
      ex_rt_addr   <= '0;
      ex_rs_val    <= '0;
      ex_rt_val    <= '0;
      ex_imm       <= '0;
      ex_shamt     <= '0;
      ex_alu_conf  <= ALU_AND;
      ex_sign      <= 1'b0;
      ex_alu_src1  <= 1'b0;
      ex_alu_src2  <= 1'b0;
      ex_dst       <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (ex_hold) begin
      // A producer may retire during the hold; keep whatever it supplied.
      if (rs_sel != FWD_REG) ex_rs_val <= rs_fwd;
      if (rt_sel != FWD_REG) ex_rt_val <= rt_fwd;
    end else if (flush || lu) begin
      ex_valid     <= 1'b0;
      ex_rs_addr   <= '0;
      ex_rt_addr   <= '0;
      ex_rs_val    <= '0;
      ex_rt_val    <= '0;
      ex_imm       <= '0;
      ex_shamt     <= '0;
      ex_alu_conf  <= ALU_AND;
      ex_sign      <= 1'b0;
      ex_alu_src1  <= 1'b0;
      ex_alu_src2  <= 1'b0;
      ex_dst       <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else begin
      ex_valid     <= id_valid;
      ex_rs_addr   <= id_rs_addr;
      ex_rt_addr   <= id_rt_addr;
      ex_rs_val    <= (rs_byp_sel == FWD_REG) ? id_rs_data : rs_byp;
      ex_rt_val    <= (rt_byp_sel == FWD_REG) ? id_rt_data : rt_byp;
      ex_imm       <= id_imm;
      ex_shamt     <= id_shamt;
      ex_alu_conf  <= id_alu_conf;
      ex_sign      <= id_sign;
      ex_alu_src1  <= id_alu_src1;
      ex_alu_src2  <= id_alu_src2;
      ex_dst       <= id_dst_addr;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      ex_mem_write <= id_mem_write;
    end
  end

  // ALU operand selection; in1 carries the shift amount for shift ops.
  always_comb begin
    ex_in1        = ex_alu_src1 ? {{(DW-5){1'b0}}, ex_shamt} : rs_fwd;
    ex_in2        = ex_alu_src2 ? ex_imm : rt_fwd;
    ex_store_data = rt_fwd;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding, load-use, operand select, hold/flush, reset.
module tb_id_ex_stage;
  import pipe_pkg::*;

  logic        clk, rst_n;
  logic        id_valid, id_uses_rs, id_uses_rt;
  logic [4:0]  id_rs_addr, id_rt_addr, id_dst_addr, id_shamt, id_alu_conf;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_sign, id_alu_src1, id_alu_src2;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        flush, ex_hold;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_dst, memwb_dst;
  logic [31:0] exmem_result, memwb_data;
  logic        stall_id, ex_valid, ex_sign, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_alu_conf, ex_dst;
  logic [31:0] ex_in1, ex_in2, ex_store_data;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_stage #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alu_conf(id_alu_conf), .id_sign(id_sign),
    .id_alu_src1(id_alu_src1), .id_alu_src2(id_alu_src2), .id_dst_addr(id_dst_addr),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush(flush), .ex_hold(ex_hold),
    .exmem_reg_write(exmem_reg_write), .exmem_dst(exmem_dst), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_dst(memwb_dst), .memwb_data(memwb_data),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_alu_conf(ex_alu_conf), .ex_sign(ex_sign),
    .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_store_data(ex_store_data), .ex_dst(ex_dst),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic id_clear();
    id_valid = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_rs_data = 0; id_rt_data = 0;
    id_imm = 0; id_shamt = 0; id_alu_conf = 0; id_sign = 0;
    id_alu_src1 = 0; id_alu_src2 = 0; id_dst_addr = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
  endtask

  initial begin
    rst_n = 0; flush = 0; ex_hold = 0;
    exmem_reg_write = 0; exmem_dst = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_dst = 0; memwb_data = 0;
    id_clear();

    // Reset state
    #12;
    chk("rst_valid", ex_valid, 0);
    chk("rst_conf", ex_alu_conf, 0);
    chk("rst_stall", stall_id, 0);
    chk("rst_in1", ex_in1, 0);
    rst_n = 1;

    // Plain capture of add r7 = r5 + r6
    id_valid = 1; id_uses_rs = 1; id_uses_rt = 1;
    id_rs_addr = 5; id_rt_addr = 6; id_rs_data = 32'h1; id_rt_data = 32'h2;
    id_alu_conf = ALU_ADD; id_dst_addr = 7; id_reg_write = 1;
    tick();
    chk("cap_valid", ex_valid, 1);
    chk("cap_conf", ex_alu_conf, ALU_ADD);
    chk("cap_dst", ex_dst, 7);
    chk("cap_regw", ex_reg_write, 1);
    chk("cap_in1", ex_in1, 32'h1);
    chk("cap_in2", ex_in2, 32'h2);

    // EX/MEM forward and priority over MEM/WB
    exmem_reg_write = 1; exmem_dst = 5; exmem_result = 32'h10;
    #1 chk("fwd_exmem", ex_in1, 32'h10);
    memwb_reg_write = 1; memwb_dst = 5; memwb_data = 32'h20;
    #1 chk("fwd_prio", ex_in1, 32'h10);
    exmem_reg_write = 0;
    #1 chk("fwd_memwb", ex_in1, 32'h20);
    memwb_reg_write = 0;
    #1 chk("fwd_none", ex_in1, 32'h1);

    // WB bypass at capture
    id_rs_addr = 9; id_rs_data = 32'h3;
    memwb_reg_write = 1; memwb_dst = 9; memwb_data = 32'h99;
    tick();
    memwb_reg_write = 0;
    #1 chk("wb_bypass", ex_in1, 32'h99);

    // Load-use: lw r8, 4(r1) then add r3 = r8 + r2
    id_clear();
    id_valid = 1; id_uses_rs = 1; id_rs_addr = 1; id_rs_data = 32'h100;
    id_alu_src2 = 1; id_imm = 32'h4; id_alu_conf = ALU_ADD;
    id_dst_addr = 8; id_mem_read = 1; id_reg_write = 1;
    tick();
    chk("lw_memrd", ex_mem_read, 1);
    id_clear();
    id_valid = 1; id_uses_rs = 1; id_uses_rt = 1; id_rs_addr = 8; id_rt_addr = 2;
    id_rs_data = 32'h0; id_rt_data = 32'h7; id_alu_conf = ALU_ADD;
    id_dst_addr = 3; id_reg_write = 1;
    #1 chk("lu_stall", stall_id, 1);
    tick();
    chk("bub_valid", ex_valid, 0);
    chk("bub_regw", ex_reg_write, 0);
    chk("bub_memrd", ex_mem_read, 0);
    chk("bub_conf", ex_alu_conf, 0);
    chk("bub_stall", stall_id, 0);
    memwb_reg_write = 1; memwb_dst = 8; memwb_data = 32'hAB;
    tick();
    chk("lu_valid", ex_valid, 1);
    chk("lu_in1", ex_in1, 32'hAB);
    chk("lu_in2", ex_in2, 32'h7);
    memwb_reg_write = 0;
    #1 chk("lu_in1_kept", ex_in1, 32'hAB);

    // Zero register never forwarded
    id_clear();
    id_valid = 1; id_uses_rs = 1; id_rs_addr = 0; id_rs_data = 0;
    id_alu_conf = ALU_OR; id_dst_addr = 4; id_reg_write = 1;
    tick();
    exmem_reg_write = 1; exmem_dst = 0; exmem_result = 32'hDEAD;
    memwb_reg_write = 1; memwb_dst = 0; memwb_data = 32'hBEEF;
    #1 chk("zero_reg", ex_in1, 32'h0);
    exmem_reg_write = 0; memwb_reg_write = 0;

    // Shift amount and immediate select
    id_clear();
    id_valid = 1; id_uses_rt = 1; id_rs_addr = 4; id_rt_addr = 6;
    id_rt_data = 32'h11; id_alu_src1 = 1; id_shamt = 4;
    id_alu_src2 = 1; id_imm = 32'hFFFF_FFF0; id_alu_conf = ALU_SLL;
    id_dst_addr = 9; id_reg_write = 1;
    tick();
    exmem_reg_write = 1; exmem_dst = 4; exmem_result = 32'h77;
    #1 chk("shamt_in1", ex_in1, 32'h4);
    chk("imm_in2", ex_in2, 32'hFFFF_FFF0);
    chk("store_rt", ex_store_data, 32'h11);
    exmem_dst = 6; exmem_result = 32'h66;
    #1 chk("store_fwd", ex_store_data, 32'h66);
    chk("imm_in2_fwd", ex_in2, 32'hFFFF_FFF0);
    exmem_reg_write = 0;

    // Hold for three edges while MEM/WB supplies rs then retires; flush ignored
    id_clear();
    id_valid = 1; id_uses_rs = 1; id_rs_addr = 10; id_rs_data = 32'h1;
    id_alu_conf = ALU_OR; id_dst_addr = 11; id_reg_write = 1;
    tick();
    memwb_reg_write = 1; memwb_dst = 10; memwb_data = 32'h55; ex_hold = 1;
    id_alu_conf = ALU_XOR; id_dst_addr = 12;
    #1 chk("hold_stall", stall_id, 1);
    chk("hold_in1_fwd", ex_in1, 32'h55);
    tick();
    memwb_reg_write = 0; flush = 1;
    #1 chk("hold_in1_kept", ex_in1, 32'h55);
    tick();
    chk("hold_valid", ex_valid, 1);
    chk("hold_conf", ex_alu_conf, ALU_OR);
    tick();
    chk("hold_in1_end", ex_in1, 32'h55);
    chk("hold_dst", ex_dst, 11);
    ex_hold = 0;
    tick();
    chk("flush_valid", ex_valid, 0);
    chk("flush_regw", ex_reg_write, 0);
    chk("flush_conf", ex_alu_conf, 0);
    flush = 0;

    // Asynchronous reset mid-cycle
    tick();
    chk("pre_rst_valid", ex_valid, 1);
    rst_n = 0;
    #1 chk("arst_valid", ex_valid, 0);
    chk("arst_regw", ex_reg_write, 0);
    chk("arst_dst", ex_dst, 0);
    #3 rst_n = 1;
    tick();
    chk("post_rst_valid", ex_valid, 1);
    chk("post_rst_dst", ex_dst, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage feeding the ALU: registers the decoded instruction, resolves data hazards with forwarding, and drives the ALU's `ALUConf`/`Sign`/`in1`/`in2` inputs. It also detects load-use hazards, inserts bubbles, and honours flush and hold from the hazard/branch logic. It sits between the register-file read stage and the ALU/EX-MEM register.

## Interface
Parameters:
- `DW`, default 32: data width.
- `AW`, default 5: register address width.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: asynchronous reset, active-low.
- `id_valid`, in, 1: ID-stage instruction present.
- `id_rs_addr` / `id_rt_addr`, in, AW: source registers.
- `id_uses_rs` / `id_uses_rt`, in, 1: instruction actually reads rs / rt.
- `id_rs_data` / `id_rt_data`, in, DW: register-file read data.
- `id_imm`, in, DW: already-extended immediate.
- `id_shamt`, in, 5: shift amount.
- `id_alu_conf`, in, 5: ALU operation code.
- `id_sign`, in, 1: signed compare.
- `id_alu_src1`, in, 1: 0 = rs, 1 = zero-extended shamt.
- `id_alu_src2`, in, 1: 0 = rt, 1 = imm.
- `id_dst_addr`, in, AW: destination register.
- `id_reg_write` / `id_mem_read` / `id_mem_write`, in, 1: control bits.
- `flush`, in, 1: squash the ID instruction.
- `ex_hold`, in, 1: downstream stall; freeze the EX register.
- `exmem_reg_write`, in, 1; `exmem_dst`, in, AW; `exmem_result`, in, DW: EX/MEM forward source.
- `memwb_reg_write`, in, 1; `memwb_dst`, in, AW; `memwb_data`, in, DW: MEM/WB forward source.
- `stall_id`, out, 1: ID must hold its instruction.
- `ex_valid`, out, 1: EX register holds a live instruction.
- `ex_alu_conf`, out, 5; `ex_sign`, out, 1: to the ALU.
- `ex_in1` / `ex_in2`, out, DW: ALU operands.
- `ex_store_data`, out, DW: forwarded rt, used for stores.
- `ex_dst`, out, AW; `ex_reg_write` / `ex_mem_read` / `ex_mem_write`, out, 1: to EX/MEM.

## Operation
- **EX register fields:** valid, rs/rt addresses, rs/rt values, imm, shamt, conf, sign, src selects, dst, control bits.
- **Capture.** When the register updates normally, each captured rs/rt value is WB-bypassed first.
  - If `memwb_reg_write`, `memwb_dst` equals the address, and the address is non-zero, capture `memwb_data`.
  - Otherwise capture the `id_*_data` value.
- **Load-use hazard:**
  - `lu` = `ex_valid & ex_mem_read & ex_dst != 0 & id_valid & ((id_uses_rs & id_rs_addr == ex_dst) | (id_uses_rt & id_rt_addr == ex_dst))`.
  - `stall_id` = `lu | ex_hold`.
- **Update priority each edge (highest first):**
  1. `ex_hold`: control fields are frozen. The rs/rt value registers re-latch their currently forwarded values, so a producer that leaves MEM/WB during the hold is not lost.
  2. `flush`: load a bubble.
  3. `lu`: load a bubble.
  4. Otherwise capture the ID fields, with `ex_valid` = `id_valid`.
- **Flush vs hold:** `flush` asserted while `ex_hold` = 1 is ignored. The flush source must keep it asserted until hold drops.
- **Bubble:** `ex_valid`, `ex_reg_write`, `ex_mem_read`, and `ex_mem_write` all = 0; `ex_alu_conf` = AND (0). The remaining fields are don't-care and are zeroed.
- **Forwarding (combinational, per source register r):**
  - EX/MEM if `exmem_reg_write & exmem_dst == r & r != 0`.
  - Else MEM/WB if `memwb_reg_write & memwb_dst == r & r != 0`.
  - Else the registered value.
  - EX/MEM always beats MEM/WB. Register 0 is never forwarded.
- **Operand select:**
  - `ex_in1` = `ex_alu_src1` ? {27'b0, shamt} : forwarded rs. The ALU shifts `in2` by `in1`.
  - `ex_in2` = `ex_alu_src2` ? imm : forwarded rt.
  - `ex_store_data` = forwarded rt, regardless of `ex_alu_src2`.
- **Width:** all data paths are DW bits. There is no arithmetic in this block.

## Timing
- **Latency:** 1 cycle from ID inputs to EX outputs. Forwarding into `ex_in*` is combinational, in the same cycle as the EX/MEM / MEM/WB inputs.
- **Load-use:** exactly one bubble per hazard. In the cycle after the bubble, the dependent instruction is captured and its operand is forwarded from MEM/WB.
- **`stall_id`:** combinational and valid in the same cycle as its cause.
- **Reset:** asynchronous, active-low, and may occur mid-operation.
  - Every registered field clears immediately: `ex_valid` = 0, all control = 0, `ex_alu_conf` = 0, `ex_dst` = 0, `ex_sign` = 0.
  - `ex_in1`, `ex_in2`, and `ex_store_data` reflect zeroed registers plus any live forwarding.
  - The first capture happens on the first rising edge after `rst_n` rises.
- **Simultaneous flush and `lu`:** bubble. `stall_id` still reflects `lu`.

## Structure
- **Shared package `pipe_pkg`:**
  - ALU conf constants (5-bit): AND = 0, OR = 1, ADD = 2, SUB = 3, SLT = 4, NOR = 5, XOR = 6, SLL = 7, SRL = 8, SRA = 9.
  - Forward-select enum: FWD_REG, FWD_EXMEM, FWD_MEMWB.
- **Sub-module `fwd_mux`:** source address, registered value, the two forward sources, and their enables in; forwarded value and select out. It is instantiated twice (rs, rt) and reused for the WB bypass at capture.

## Test plan
- **EX/MEM forward:** EX add reads r5; `exmem_reg_write` = 1, `exmem_dst` = 5, `exmem_result` = 0x10 -> `ex_in1` = 0x10 in the same cycle.
- **Forward priority:** `exmem_dst` = `memwb_dst` = 5 with results 0x10 / 0x20 -> `ex_in1` = 0x10. With `exmem_reg_write` = 0 -> 0x20.
- **Load-use hazard:**
  - Setup: EX holds lw to r8; ID add uses rs = r8.
  - Hazard cycle: `stall_id` = 1 for one cycle, then `ex_valid` = 0 with all control 0.
  - Next cycle: add captured; `memwb_dst` = 8 with data 0xAB -> `ex_in1` = 0xAB.
- **Zero register:** `exmem_reg_write` = 1, `exmem_dst` = 0, `exmem_result` = 0xDEAD, EX rs = 0 with captured value 0 -> `ex_in1` = 0.
- **Shift/immediate select:** `alu_src1` = 1, shamt = 4 with a rs forward pending -> `ex_in1` = 4. `alu_src2` = 1, imm = 0xFFFF_FFF0 -> `ex_in2` = 0xFFFF_FFF0, while `ex_store_data` = forwarded rt.
- **Hold and reset:**
  - Hold 3 cycles while MEM/WB supplies rs = 0x55 then retires -> `ex_in1` stays 0x55 and `flush` is ignored.
  - Drop hold with `flush` = 1 -> bubble.
  - `rst_n` low mid-cycle -> `ex_valid` = 0 immediately.
